// File: rtl/jpeg_dequant_block_builder_if.sv
// Token, quant-table write and block output signals of the JPEG dequant block builder.
// The master side drives tokens, table writes and out_ready; the slave side is the builder.
interface jpeg_dequant_block_builder_if #(
    parameter int COEF_W   = 12,
    parameter int QUANT_W  = 8,
    parameter int OUT_W    = 16,
    parameter int QT_SEL_W = 2
);
    logic                       in_valid;
    logic                       in_ready;
    logic [3:0]                 in_run;
    logic signed [COEF_W-1:0]   in_coef;
    logic                       in_eob;
    logic [QT_SEL_W-1:0]        in_qt_sel;
    logic                       qt_wr_en;
    logic [QT_SEL_W-1:0]        qt_wr_sel;
    logic [5:0]                 qt_wr_addr;
    logic [QUANT_W-1:0]         qt_wr_data;
    logic                       out_valid;
    logic                       out_ready;
    logic [64*OUT_W-1:0]        out_block;
    logic [QT_SEL_W-1:0]        out_qt_sel;
    logic                       err_overrun;

    modport master (
        output in_valid, in_run, in_coef, in_eob, in_qt_sel,
               qt_wr_en, qt_wr_sel, qt_wr_addr, qt_wr_data, out_ready,
        input  in_ready, out_valid, out_block, out_qt_sel, err_overrun
    );

    modport slave (
        input  in_valid, in_run, in_coef, in_eob, in_qt_sel,
               qt_wr_en, qt_wr_sel, qt_wr_addr, qt_wr_data, out_ready,
        output in_ready, out_valid, out_block, out_qt_sel, err_overrun
    );
endinterface

// File: rtl/jpeg_dequant_block_builder.sv
// Places run-length coefficient tokens at their natural 8x8 positions, dequantises them with
// saturation, and ping-pongs completed blocks to the IDCT behind a ready/valid handshake.
module jpeg_dequant_block_builder #(
    parameter int COEF_W   = 12,
    parameter int QUANT_W  = 8,
    parameter int OUT_W    = 16,
    parameter int NUM_QT   = 4,
    parameter int QT_SEL_W = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    jpeg_dequant_block_builder_if.slave bus
);
    localparam int PROD_W = COEF_W + QUANT_W + 1;

    localparam logic signed [PROD_W-1:0] SAT_MAX = {{(PROD_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [PROD_W-1:0] SAT_MIN = ~SAT_MAX;

    localparam int ZZ_MAP [64] = '{
         0,  1,  8, 16,  9,  2,  3, 10,
        17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34,
        27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36,
        29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46,
        53, 60, 61, 54, 47, 55, 62, 63
    };

    typedef logic [QT_SEL_W-1:0] sel_t;

    function automatic logic signed [PROD_W-1:0] mul(input logic signed [COEF_W-1:0] c,
                                                     input logic [QUANT_W-1:0]      q);
        logic signed [PROD_W-1:0] c_x;
        logic signed [PROD_W-1:0] q_x;
        c_x = {{(QUANT_W+1){c[COEF_W-1]}}, c};
        q_x = {{(COEF_W+1){1'b0}}, q};
        return c_x * q_x;
    endfunction

    function automatic logic signed [OUT_W-1:0] sat(input logic signed [PROD_W-1:0] p);
        if (p > SAT_MAX)      return SAT_MAX[OUT_W-1:0];
        else if (p < SAT_MIN) return SAT_MIN[OUT_W-1:0];
        else                  return p[OUT_W-1:0];
    endfunction

    logic [QUANT_W-1:0]      qt_q  [NUM_QT][64];
    logic signed [OUT_W-1:0] blk_q [2][64];

    logic [63:0] mask_q [2];
    logic [63:0] mask_d [2];
    sel_t        buf_sel_q [2];
    sel_t        buf_sel_d [2];
    logic [1:0]  full_q, full_d;
    logic        fill_ptr_q, fill_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [5:0]  pos_q, pos_d;
    sel_t        blk_sel_q, blk_sel_d;
    logic        out_valid_q, out_valid_d;
    logic        err_q, err_d;

    logic                    in_ready_c, acc, xfer, close;
    logic [6:0]              zz;
    sel_t                    cur_sel;
    logic [QUANT_W-1:0]      q_ent;
    logic                    wr_en;
    logic [5:0]              wr_idx;
    logic signed [OUT_W-1:0] wr_val;
    logic [64*OUT_W-1:0]     out_block_c;

    assign in_ready_c = !rst && !full_q[fill_ptr_q];
    assign acc        = bus.in_valid && in_ready_c;
    assign xfer       = out_valid_q && bus.out_ready;
    assign zz         = {1'b0, pos_q} + {3'b000, bus.in_run};
    assign cur_sel    = (pos_q == 6'd0) ? bus.in_qt_sel : blk_sel_q;

    // Table lookup reads the registered table, so a same-cycle write is seen only afterwards.
    always_comb begin
        q_ent = '0;
        for (int t = 0; t < NUM_QT; t++) begin
            if (sel_t'(t) == cur_sel) q_ent = qt_q[t][zz[5:0]];
        end
    end

    always_comb begin
        full_d     = full_q;
        fill_ptr_d = fill_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        pos_d      = pos_q;
        blk_sel_d  = blk_sel_q;
        buf_sel_d  = buf_sel_q;
        mask_d     = mask_q;
        err_d      = 1'b0;
        close      = 1'b0;
        wr_en      = 1'b0;
        wr_idx     = 6'(ZZ_MAP[zz[5:0]]);
        wr_val     = sat(mul(bus.in_coef, q_ent));

        if (acc) begin
            blk_sel_d             = cur_sel;
            buf_sel_d[fill_ptr_q] = cur_sel;
            if (bus.in_eob) begin
                close = 1'b1;
            end else if (zz[6]) begin
                err_d = 1'b1;
                close = 1'b1;
            end else begin
                wr_en                      = 1'b1;
                mask_d[fill_ptr_q][wr_idx] = 1'b1;
                if (zz[5:0] == 6'd63) close = 1'b1;
                else                  pos_d = zz[5:0] + 6'd1;
            end
        end

        if (close) begin
            full_d[fill_ptr_q] = 1'b1;
            fill_ptr_d         = ~fill_ptr_q;
            pos_d              = 6'd0;
        end

        // Emptying a buffer also wipes its mask, so it is clean whenever it becomes fillable.
        if (xfer) begin
            full_d[rd_ptr_q] = 1'b0;
            mask_d[rd_ptr_q] = '0;
            rd_ptr_d         = ~rd_ptr_q;
        end

        out_valid_d = full_q[rd_ptr_d] || (xfer && close);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q      <= '0;
            fill_ptr_q  <= 1'b0;
            rd_ptr_q    <= 1'b0;
            pos_q       <= '0;
            blk_sel_q   <= '0;
            buf_sel_q   <= '{default: '0};
            mask_q      <= '{default: '0};
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            full_q      <= full_d;
            fill_ptr_q  <= fill_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            pos_q       <= pos_d;
            blk_sel_q   <= blk_sel_d;
            buf_sel_q   <= buf_sel_d;
            mask_q      <= mask_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) blk_q[fill_ptr_q][wr_idx] <= wr_val;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int t = 0; t < NUM_QT; t++) begin
                for (int e = 0; e < 64; e++) qt_q[t][e] <= QUANT_W'(1);
            end
        end else begin
            for (int t = 0; t < NUM_QT; t++) begin
                if (bus.qt_wr_en && bus.qt_wr_sel == sel_t'(t)) qt_q[t][bus.qt_wr_addr] <= bus.qt_wr_data;
            end
        end
    end

    always_comb begin
        out_block_c = '0;
        for (int k = 0; k < 64; k++) begin
            if (mask_q[rd_ptr_q][k]) out_block_c[k*OUT_W +: OUT_W] = blk_q[rd_ptr_q][k];
        end
    end

    assign bus.in_ready    = in_ready_c;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_block   = out_block_c;
    assign bus.out_qt_sel  = buf_sel_q[rd_ptr_q];
    assign bus.err_overrun = err_q;
endmodule

// File: tb/tb_jpeg_dequant_block_builder.sv
// Directed bench for jpeg_dequant_block_builder: table-driven dequant/saturation vectors plus
// hand-written sequences for latency, overrun, backpressure, simultaneous events and reset.
module tb_jpeg_dequant_block_builder;
    localparam int COEF_W   = 12;
    localparam int QUANT_W  = 8;
    localparam int OUT_W    = 16;
    localparam int NUM_QT   = 4;
    localparam int QT_SEL_W = 2;

    localparam int ZZ [64] = '{
         0,  1,  8, 16,  9,  2,  3, 10,
        17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34,
        27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36,
        29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46,
        53, 60, 61, 54, 47, 55, 62, 63
    };

    typedef logic signed [OUT_W-1:0] samp_t;

    typedef struct {
        int coef;
        int q;
        int zz;
        int expv;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    jpeg_dequant_block_builder_if #(.COEF_W(COEF_W), .QUANT_W(QUANT_W), .OUT_W(OUT_W),
                                    .QT_SEL_W(QT_SEL_W)) bus ();

    jpeg_dequant_block_builder #(.COEF_W(COEF_W), .QUANT_W(QUANT_W), .OUT_W(OUT_W),
                                 .NUM_QT(NUM_QT), .QT_SEL_W(QT_SEL_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int    n_checks = 0;
    int    n_pass   = 0;
    samp_t exp_blk [64];
    samp_t got_blk [64];
    int    got_sel;
    vec_t  vecs [8];

    task automatic check(input string name, input int got, input int expv);
        n_checks++;
        if (got == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, expv);
    endtask

    task automatic check_block(input string name);
        int bad;
        bad = -1;
        for (int k = 63; k >= 0; k--) if (got_blk[k] !== exp_blk[k]) bad = k;
        n_checks++;
        if (bad < 0) n_pass++;
        else $display("FAIL %s: element %0d got %0d expected %0d", name, bad, got_blk[bad], exp_blk[bad]);
    endtask

    task automatic clear_exp();
        for (int k = 0; k < 64; k++) exp_blk[k] = '0;
    endtask

    task automatic sample_block();
        for (int k = 0; k < 64; k++) got_blk[k] = bus.out_block[k*OUT_W +: OUT_W];
        got_sel = int'(bus.out_qt_sel);
    endtask

    task automatic qt_write(input int sel, input int addr, input int data);
        bus.qt_wr_en   = 1'b1;
        bus.qt_wr_sel  = QT_SEL_W'(sel);
        bus.qt_wr_addr = 6'(addr);
        bus.qt_wr_data = QUANT_W'(data);
        @(posedge clk); #1;
        bus.qt_wr_en   = 1'b0;
    endtask

    task automatic send_tok(input int run, input int coef, input bit eob, input int sel);
        bit acc;
        acc = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_run    = 4'(run);
        bus.in_coef   = COEF_W'(coef);
        bus.in_eob    = eob;
        bus.in_qt_sel = QT_SEL_W'(sel);
        for (int n = 0; n < 100 && !acc; n++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.in_eob   = 1'b0;
        if (!acc) check("tok_accept", int'(acc), 1);
    endtask

    task automatic get_block(input string name);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        check({name, "_valid"}, int'(seen), 1);
        sample_block();
        if (seen) begin
            bus.out_ready = 1'b1;
            @(posedge clk); #1;
            bus.out_ready = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{coef:  2047, q: 255, zz:  0, expv:  32767};
        vecs[1] = '{coef: -2048, q: 255, zz:  0, expv: -32768};
        vecs[2] = '{coef:   100, q: 200, zz: 10, expv:  20000};
        vecs[3] = '{coef:  -100, q: 200, zz: 10, expv: -20000};
        vecs[4] = '{coef:  -128, q: 255, zz: 15, expv: -32640};
        vecs[5] = '{coef:   129, q: 255, zz: 15, expv:  32767};
        vecs[6] = '{coef:  -129, q: 255, zz: 15, expv: -32768};
        vecs[7] = '{coef:     7, q:   0, zz:  3, expv:      0};

        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_run = '0; bus.in_coef = '0; bus.in_eob = 1'b0; bus.in_qt_sel = '0;
        bus.qt_wr_en = 1'b0; bus.qt_wr_sel = '0; bus.qt_wr_addr = '0; bus.qt_wr_data = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", int'(bus.in_ready), 0);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_err", int'(bus.err_overrun), 0);
        check("rst_out_qt_sel", int'(bus.out_qt_sel), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", int'(bus.in_ready), 1);
        @(posedge clk); #1;

        // Basic block with pass-through table and latency of out_valid.
        send_tok(0, 5, 0, 0);
        send_tok(0, -3, 0, 0);
        send_tok(0, 0, 1, 0);
        check("t1_valid_at_close", int'(bus.out_valid), 0);
        @(posedge clk); #1;
        check("t1_valid_next", int'(bus.out_valid), 1);
        get_block("t1");
        clear_exp(); exp_blk[0] = 5; exp_blk[1] = -3;
        check_block("t1_block");
        check("t1_sel", got_sel, 0);

        // Table select latched on first token; later in_qt_sel ignored.
        qt_write(1, 0, 16);
        qt_write(1, 1, 11);
        qt_write(2, 2, 3);
        send_tok(0, 10, 0, 1);
        send_tok(1, 22, 0, 2);
        send_tok(0, 0, 1, 2);
        get_block("t2");
        clear_exp(); exp_blk[0] = 160; exp_blk[8] = 22;
        check_block("t2_block");
        check("t2_sel", got_sel, 1);

        // Full block of 64 tokens closes without EOB.
        for (int k = 0; k < 64; k++) send_tok(0, k + 1, 0, 0);
        get_block("t3");
        clear_exp();
        for (int k = 0; k < 64; k++) exp_blk[ZZ[k]] = samp_t'(k + 1);
        check_block("t3_block");
        check("t3_err", int'(bus.err_overrun), 0);

        // Table-driven dequant and saturation vectors on table 3.
        for (int i = 0; i < 8; i++) begin
            qt_write(3, vecs[i].zz, vecs[i].q);
            send_tok(vecs[i].zz, vecs[i].coef, 0, 3);
            send_tok(0, 0, 1, 3);
            get_block($sformatf("vec%0d", i));
            clear_exp(); exp_blk[ZZ[vecs[i].zz]] = samp_t'(vecs[i].expv);
            check_block($sformatf("vec%0d_block", i));
            check($sformatf("vec%0d_sel", i), got_sel, 3);
        end

        // Table write colliding with a multiply on the same entry: old value is used.
        qt_write(3, 0, 2);
        bus.qt_wr_en = 1'b1; bus.qt_wr_sel = 2'd3; bus.qt_wr_addr = 6'd0; bus.qt_wr_data = 8'd5;
        send_tok(0, 10, 0, 3);
        bus.qt_wr_en = 1'b0;
        send_tok(0, 0, 1, 3);
        get_block("wr_same");
        clear_exp(); exp_blk[0] = 20;
        check_block("wr_same_block");
        send_tok(0, 10, 0, 3);
        send_tok(0, 0, 1, 3);
        get_block("wr_after");
        clear_exp(); exp_blk[0] = 50;
        check_block("wr_after_block");

        // Overrun from pos 60 with run 5.
        send_tok(15, 1, 0, 0);
        send_tok(15, 2, 0, 0);
        send_tok(15, 3, 0, 0);
        send_tok(11, 4, 0, 0);
        check("ovr_err_before", int'(bus.err_overrun), 0);
        send_tok(5, 9, 0, 0);
        check("ovr_err_pulse", int'(bus.err_overrun), 1);
        @(posedge clk); #1;
        check("ovr_err_clear", int'(bus.err_overrun), 0);
        get_block("ovr");
        clear_exp(); exp_blk[5] = 1; exp_blk[28] = 2; exp_blk[51] = 3; exp_blk[54] = 4;
        check_block("ovr_block");
        send_tok(0, 9, 0, 0);
        send_tok(0, 0, 1, 0);
        get_block("ovr_next");
        clear_exp(); exp_blk[0] = 9;
        check_block("ovr_next_block");

        // Backpressure with both buffers full, then simultaneous close and transfer.
        send_tok(0, 1, 0, 0);
        send_tok(0, 0, 1, 0);
        send_tok(0, 2, 0, 0);
        send_tok(0, 0, 1, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("bp_in_ready_low", int'(bus.in_ready), 0);
        check("bp_valid", int'(bus.out_valid), 1);
        sample_block();
        clear_exp(); exp_blk[0] = 1;
        check_block("bp_block_a");
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("bp_valid_after_xfer", int'(bus.out_valid), 1);
        check("bp_in_ready_back", int'(bus.in_ready), 1);
        sample_block();
        clear_exp(); exp_blk[0] = 2;
        check_block("bp_block_b");
        send_tok(0, 3, 0, 0);
        bus.in_valid = 1'b1; bus.in_eob = 1'b1; bus.out_ready = 1'b1;
        @(negedge clk);
        check("sim_in_ready", int'(bus.in_ready), 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.in_eob = 1'b0; bus.out_ready = 1'b0;
        check("sim_valid_stays", int'(bus.out_valid), 1);
        sample_block();
        clear_exp(); exp_blk[0] = 3;
        check_block("sim_block_c");
        get_block("sim_drain");
        check("sim_valid_empty", int'(bus.out_valid), 0);

        // Mid-block reset discards a full and a partial buffer and restores the tables.
        send_tok(0, 8, 0, 0);
        send_tok(0, 0, 1, 0);
        send_tok(0, 7, 0, 3);
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("mrst_in_ready", int'(bus.in_ready), 0);
        check("mrst_valid", int'(bus.out_valid), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mrst_valid_after", int'(bus.out_valid), 0);
        @(posedge clk); #1;
        send_tok(0, 10, 0, 3);
        send_tok(0, 0, 1, 3);
        get_block("mrst_blk");
        clear_exp(); exp_blk[0] = 10;
        check_block("mrst_block");

        // EOB as the first token gives an all-zero block.
        send_tok(0, 0, 1, 1);
        get_block("eob0");
        clear_exp();
        check_block("eob0_block");
        check("eob0_sel", got_sel, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
